instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/instr_queue_if.sv | 34 +++
 rtl/iq_ptr.sv | 23 ++
 rtl/instr_queue.sv | 105 ++++++++++
 tb/tb_instr_queue.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Holds the default datapath width, the fetch-halt encoding, the base
// opcode constants and the instruction-queue control state type.
package cpu_pkg;

    localparam int unsigned CPU_XLEN      = 32;
    localparam logic [31:0] CPU_HALT_WORD = 32'hFFFF_FFFF;

    // Base opcode field values (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Instruction-queue control state
    typedef logic [0:0] iq_state_t;
    localparam iq_state_t IQ_RUN  = 1'b0;
    localparam iq_state_t IQ_HALT = 1'b1;

endpackage

// File: rtl/instr_queue_if.sv
// Instruction-queue bus between fetch/ROB (master) and the queue (slave).
// Carries the enqueue handshake, the dequeue handshake, flush, the
// occupancy count and the halted status.
interface instr_queue_if
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = CPU_XLEN,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            enq_valid;
    logic [XLEN-1:0] enq_instr;
    logic [XLEN-1:0] enq_pc;
    logic            enq_ready;
    logic            deq_valid;
    logic [XLEN-1:0] deq_instr;
    logic [XLEN-1:0] deq_pc;
    logic            deq_ready;
    logic            flush;
    logic [CW-1:0]   count;
    logic            halted;

    modport master (
        output enq_valid, enq_instr, enq_pc, deq_ready, flush,
        input  enq_ready, deq_valid, deq_instr, deq_pc, count, halted
    );

    modport slave (
        input  enq_valid, enq_instr, enq_pc, deq_ready, flush,
        output enq_ready, deq_valid, deq_instr, deq_pc, count, halted
    );

endinterface

// File: rtl/iq_ptr.sv
// Wrap-around FIFO pointer.
// Ports: clock, reset (sync, active-high), clr (sync clear), inc (advance),
// ptr (current index, wraps DEPTH-1 -> 0).
module iq_ptr #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);
    localparam int unsigned AW = $clog2(DEPTH);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode/issue.
// Ports: clock, reset (sync, active-high), q (instr_queue_if.slave):
//   enq_valid/enq_instr/enq_pc/enq_ready  - fetch side
//   deq_valid/deq_instr/deq_pc/deq_ready  - decode side
//   flush - ROB redirect, count - occupancy, halted - HALT_WORD accepted.
module instr_queue
    import cpu_pkg::*;
#(
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     XLEN      = CPU_XLEN,
    parameter logic [XLEN-1:0] HALT_WORD = XLEN'(CPU_HALT_WORD)
) (
    input  logic          clock,
    input  logic          reset,
    instr_queue_if.slave  q
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    iq_state_t     state_q;
    iq_state_t     state_d;

    logic empty;
    logic full;
    logic do_enq;
    logic do_deq;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A dequeue never frees a slot for a same-cycle enqueue at full.
    assign q.enq_ready = !full && (state_q == IQ_RUN) && !q.flush;
    assign do_enq      = q.enq_valid && q.enq_ready;
    assign do_deq      = !empty && q.deq_ready && !q.flush;

    iq_ptr #(.DEPTH(DEPTH)) u_head (
        .clock (clock),
        .reset (reset),
        .clr   (q.flush),
        .inc   (do_deq),
        .ptr   (head)
    );

    iq_ptr #(.DEPTH(DEPTH)) u_tail (
        .clock (clock),
        .reset (reset),
        .clr   (q.flush),
        .inc   (do_enq),
        .ptr   (tail)
    );

    // Entry storage; validity is tracked by count, so no reset needed.
    always_ff @(posedge clock) begin
        if (do_enq) begin
            instr_mem[tail] <= q.enq_instr;
            pc_mem[tail]    <= q.enq_pc;
        end
    end

    // State register: occupancy and control FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            state_q <= IQ_RUN;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Next occupancy and next control state.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (q.flush) begin
            count_d = '0;
            state_d = IQ_RUN;
        end else begin
            if (do_enq && !do_deq) begin
                count_d = count_q + CW'(1);
            end else if (do_deq && !do_enq) begin
                count_d = count_q - CW'(1);
            end
            // The halt word itself is stored; only later enqueues are blocked.
            if (state_q == IQ_RUN && do_enq && q.enq_instr == HALT_WORD) begin
                state_d = IQ_HALT;
            end
        end
    end

    // Head data is forced to zero while the queue is empty.
    assign q.deq_valid = !empty;
    assign q.deq_instr = empty ? '0 : instr_mem[head];
    assign q.deq_pc    = empty ? '0 : pc_mem[head];
    assign q.count     = count_q;
    assign q.halted    = (state_q == IQ_HALT);

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue (DEPTH=4, XLEN=32).
module tb_instr_queue;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    bit   mon_en;
    ent_t sb [$];

    instr_queue_if #(.XLEN(32), .DEPTH(4)) iq ();

    instr_queue #(.DEPTH(4), .XLEN(32), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clock (clock),
        .reset (reset),
        .q     (iq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard monitor: model occupancy and head contents each cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            vectors++;
            if (iq.count !== 3'(sb.size())) begin
                miscompares++;
                $display("FAIL sb_count: got %0d expected %0d", iq.count, sb.size());
            end
            vectors++;
            if (iq.deq_valid !== (sb.size() != 0)) begin
                miscompares++;
                $display("FAIL sb_deq_valid: got %0b expected %0b", iq.deq_valid, sb.size() != 0);
            end
            if (sb.size() == 0) begin
                vectors++;
                if (iq.deq_pc !== 32'h0 || iq.deq_instr !== 32'h0) begin
                    miscompares++;
                    $display("FAIL sb_empty_zero: got pc=%0h instr=%0h expected 0", iq.deq_pc, iq.deq_instr);
                end
            end
            if (reset || iq.flush) begin
                sb.delete();
            end else begin
                if (iq.deq_ready && sb.size() != 0) begin
                    ent_t exp;
                    exp = sb.pop_front();
                    vectors++;
                    if (iq.deq_pc !== exp.pc || iq.deq_instr !== exp.instr) begin
                        miscompares++;
                        $display("FAIL sb_head: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                                 iq.deq_pc, iq.deq_instr, exp.pc, exp.instr);
                    end
                end
                if (iq.enq_valid && iq.enq_ready) begin
                    sb.push_back('{instr: iq.enq_instr, pc: iq.enq_pc});
                end
            end
        end
    end

    task automatic set_in(input logic ev, input logic [31:0] ins, input logic [31:0] pc,
                          input logic dr, input logic fl);
        iq.enq_valid = ev;
        iq.enq_instr = ins;
        iq.enq_pc    = pc;
        iq.deq_ready = dr;
        iq.flush     = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (iq.count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d expected 0", iq.count);
        end
        vectors++;
        if (iq.deq_valid !== 1'b0 || iq.deq_pc !== 32'h0 || iq.deq_instr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_deq: got v=%0b pc=%0h instr=%0h expected 0", iq.deq_valid, iq.deq_pc, iq.deq_instr);
        end
        vectors++;
        if (iq.halted !== 1'b0 || iq.enq_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ctrl: got halted=%0b enq_ready=%0b expected 0/1", iq.halted, iq.enq_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h1000 + base + 32'(4 * i), base + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_fill();
        fill(32'h0);
        vectors++;
        if (iq.count !== 3'd4 || iq.enq_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got count=%0d enq_ready=%0b expected 4/0", iq.count, iq.enq_ready);
        end
        vectors++;
        if (iq.deq_pc !== 32'h0 || iq.deq_instr !== 32'h1000) begin
            miscompares++;
            $display("FAIL fill_head: got pc=%0h instr=%0h expected 0/1000", iq.deq_pc, iq.deq_instr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            vectors++;
            if (iq.deq_pc !== exp_pc || iq.deq_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_order: got pc=%0h v=%0b expected %0h", iq.deq_pc, iq.deq_valid, exp_pc);
            end
            step();
            exp_pc = exp_pc + 32'd4;
            if (i < 4) begin
                set_in(1'b1, 32'h1010 + 32'(4 * i), 32'd16 + 32'(4 * i), 1'b0, 1'b0);
                step();
            end
            vectors++;
            if (iq.count > 3'd4) begin
                miscompares++;
                $display("FAIL wrap_bound: got count=%0d expected <=4", iq.count);
            end
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (iq.count !== 3'd0) begin
            miscompares++;
            $display("FAIL wrap_drain: got count=%0d expected 0", iq.count);
        end
    endtask

    task automatic test_full_simul();
        fill(32'd32);
        set_in(1'b1, 32'h2000, 32'd48, 1'b1, 1'b0);
        vectors++;
        if (iq.enq_ready !== 1'b0 || iq.count !== 3'd4 || iq.deq_pc !== 32'd32) begin
            miscompares++;
            $display("FAIL full_pre: got rdy=%0b count=%0d pc=%0h expected 0/4/20", iq.enq_ready, iq.count, iq.deq_pc);
        end
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (iq.count !== 3'd3 || iq.deq_pc !== 32'd36) begin
            miscompares++;
            $display("FAIL full_post: got count=%0d pc=%0h expected 3/24", iq.count, iq.deq_pc);
        end
    endtask

    task automatic test_flush();
        set_in(1'b1, 32'h3000, 32'h100, 1'b1, 1'b1);
        vectors++;
        if (iq.enq_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_rdy: got %0b expected 0", iq.enq_ready);
        end
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (iq.count !== 3'd0 || iq.deq_valid !== 1'b0 || iq.deq_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_clear: got count=%0d v=%0b pc=%0h expected 0", iq.count, iq.deq_valid, iq.deq_pc);
        end
        set_in(1'b1, 32'h3004, 32'h200, 1'b0, 1'b0);
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++;
        if (iq.count !== 3'd1 || iq.deq_pc !== 32'h200 || iq.deq_instr !== 32'h3004) begin
            miscompares++;
            $display("FAIL flush_restart: got count=%0d pc=%0h instr=%0h expected 1/200/3004",
                     iq.count, iq.deq_pc, iq.deq_instr);
        end
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        set_in(1'b1, 32'h0000_0001, 32'h300, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'hFFFF_FFFF, 32'h304, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'h0000_0002, 32'h308, 1'b0, 1'b0);
        vectors++;
        if (iq.halted !== 1'b1 || iq.enq_ready !== 1'b0 || iq.count !== 3'd2) begin
            miscompares++;
            $display("FAIL halt_enter: got halted=%0b rdy=%0b count=%0d expected 1/0/2",
                     iq.halted, iq.enq_ready, iq.count);
        end
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++;
        if (iq.deq_instr !== 32'h0000_0001 || iq.count !== 3'd2) begin
            miscompares++;
            $display("FAIL halt_first: got instr=%0h count=%0d expected 1/2", iq.deq_instr, iq.count);
        end
        step();
        vectors++;
        if (iq.deq_instr !== 32'hFFFF_FFFF || iq.deq_pc !== 32'h304) begin
            miscompares++;
            $display("FAIL halt_second: got instr=%0h pc=%0h expected ffffffff/304", iq.deq_instr, iq.deq_pc);
        end
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (iq.deq_valid !== 1'b0 || iq.halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_drained: got v=%0b halted=%0b expected 0/1", iq.deq_valid, iq.halted);
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (iq.halted !== 1'b0 || iq.enq_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_exit: got halted=%0b rdy=%0b expected 0/1", iq.halted, iq.enq_ready);
        end
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 32'h0000_0013, 32'h400, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'hFFFF_FFFF, 32'h404, 1'b0, 1'b0);
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (iq.count !== 3'd2 || iq.halted !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got count=%0d halted=%0b expected 2/1", iq.count, iq.halted);
        end
        reset = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (iq.count !== 3'd0 || iq.deq_instr !== 32'h0 || iq.deq_pc !== 32'h0 || iq.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_post: got count=%0d instr=%0h pc=%0h halted=%0b expected 0",
                     iq.count, iq.deq_instr, iq.deq_pc, iq.halted);
        end
        set_in(1'b1, 32'h0000_0033, 32'h500, 1'b0, 1'b0);
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++;
        if (iq.deq_pc !== 32'h500 || iq.count !== 3'd1) begin
            miscompares++;
            $display("FAIL rstmid_resume: got pc=%0h count=%0d expected 500/1", iq.deq_pc, iq.count);
        end
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        reset       = 1'b1;
        iq.enq_valid = 1'b0;
        iq.enq_instr = 32'h0;
        iq.enq_pc    = 32'h0;
        iq.deq_ready = 1'b0;
        iq.flush     = 1'b0;
        test_reset();
        test_fill();
        test_wrap();
        test_full_simul();
        test_flush();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
